// File: rtl/fp_result_fifo.sv
// fp_result_fifo: show-ahead FIFO for multiplier results with classification and drop/overflow/underflow statistics
module fp_result_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [31:0]              fp_Z,
  input  logic                     ovrf,
  input  logic                     udrf,
  input  logic [2:0]               r_mode,
  input  logic                     flush,
  input  logic                     clr_stats,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              out_data,
  output logic                     out_ovrf,
  output logic                     out_udrf,
  output logic [2:0]               out_mode,
  output logic [2:0]               out_class,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CW-1:0]            drop_cnt,
  output logic [CW-1:0]            ovrf_cnt,
  output logic [CW-1:0]            udrf_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  logic [39:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [2:0]    cls;
  logic [39:0]   head;
  logic          push, pop, drop;
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic en);
    return v + CW'(en & ~&v);
  endfunction
  // classify the incoming result: zero, subnormal, normal, inf, qNaN, sNaN
  always_comb begin
    cls = (fp_Z[30:23] == 8'h00) ? ((fp_Z[22:0] == '0) ? 3'd0 : 3'd1) :
          (fp_Z[30:23] != 8'hFF) ? 3'd2 :
          (fp_Z[22:0] == '0)     ? 3'd3 :
          fp_Z[22]               ? 3'd4 : 3'd5;
  end
  assign empty     = count == '0;
  assign full      = count == NW'(DEPTH);
  assign out_valid = !empty;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (!full | pop) & !flush;
  assign drop      = in_valid & full & !pop & !flush;
  assign head      = empty ? '0 : mem[rd_ptr];
  assign {out_data, out_ovrf, out_udrf, out_mode, out_class} = head;
  // storage array needs no reset; empty masks stale contents
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {fp_Z, ovrf, udrf, r_mode, cls};
  // pointers and occupancy; flush overrides any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(push) - NW'(pop);
    end
  end
  // saturating statistics; clear beats coincident increments
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
      ovrf_cnt <= '0;
      udrf_cnt <= '0;
    end else if (clr_stats) begin
      drop_cnt <= '0;
      ovrf_cnt <= '0;
      udrf_cnt <= '0;
    end else begin
      drop_cnt <= sat_inc(drop_cnt, drop);
      ovrf_cnt <= sat_inc(ovrf_cnt, push & ovrf);
      udrf_cnt <= sat_inc(udrf_cnt, push & udrf);
    end
  end
endmodule
